// File: rtl/mdm_mod_core.sv
// rtl/mdm_mod_core.sv - PN-driven 2ASK/2FSK/2PSK/2DPSK/QPSK modulator feeding a parallel DAC
module mdm_mod_core #(
    parameter int DAC_W       = 8,
    parameter int ADDR_W      = 7,
    parameter int CLK_DIV     = 4,
    parameter int CYC_PER_SYM = 2,
    parameter int FSK_MULT    = 2,
    parameter int PN_ORDER    = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [2:0]        mode,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DAC_W-1:0]  rom_data,
    output logic [DAC_W-1:0]  dac_data,
    output logic              clk_DA,
    output logic              blank_DA_n,
    output logic              sync_DA_n,
    output logic              sym_strobe,
    output logic [1:0]        sym_out
);
    localparam int SYM_LEN = CYC_PER_SYM * (2 ** ADDR_W);
    localparam int SYM_W   = $clog2(SYM_LEN);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int TAP     = (PN_ORDER == 9) ? 5 : (PN_ORDER == 15) ? 14 : 6;

    localparam logic [DAC_W-1:0]  MID       = DAC_W'(1) << (DAC_W - 1);
    localparam logic [ADDR_W-1:0] HALF      = ADDR_W'(1) << (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] QTR       = ADDR_W'(1) << (ADDR_W - 2);
    localparam logic [ADDR_W-1:0] STEP_MARK = ADDR_W'(FSK_MULT);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SYM_LEN - 1);

    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_ASK  = 3'd1;
    localparam logic [2:0] M_FSK  = 3'd2;
    localparam logic [2:0] M_PSK  = 3'd3;
    localparam logic [2:0] M_DPSK = 3'd4;
    localparam logic [2:0] M_QPSK = 3'd5;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_d;
    logic [SYM_W-1:0]    sym_cnt_q;
    logic                first_q;
    logic [PN_ORDER-1:0] lfsr_q;
    logic                d_q;
    logic [2:0]          mode_q;
    logic [ADDR_W-1:0]   phase_q;
    logic [1:0]          tick_dly_q;

    logic                tick;
    logic                boundary;
    logic                start;
    logic                run_on;
    logic                mute;
    logic [2:0]          mode_in;
    logic [PN_ORDER-1:0] lfsr1;
    logic [PN_ORDER-1:0] lfsr2;
    logic [PN_ORDER-1:0] new_lfsr;
    logic [1:0]          new_bits;
    logic                new_d;
    logic [2:0]          cur_mode;
    logic [1:0]          cur_bits;
    logic                cur_d;
    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   step;
    logic [ADDR_W-1:0]   phase_base;

    function automatic logic [PN_ORDER-1:0] lfsr_step(input logic [PN_ORDER-1:0] s);
        return {s[PN_ORDER-2:0], s[PN_ORDER-1] ^ s[TAP-1]};
    endfunction

    assign tick     = (state_q == S_RUN) && (div_q == DIV_LAST);
    assign boundary = tick && (first_q || (sym_cnt_q == SYM_LAST));
    // A boundary that finds enable low ends the run instead of opening a symbol.
    assign start    = boundary && enable;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (boundary && !enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        blank_DA_n = (state_q == S_RUN);
        sync_DA_n  = (state_q != S_RUN);
        sym_strobe = start;
    end

    assign run_on = (state_q == S_RUN) && (state_d == S_RUN);
    assign div_d  = !run_on ? '0 : (tick ? '0 : div_q + DIV_W'(1));

    assign mode_in  = (mode > M_QPSK) ? M_IDLE : mode;
    assign lfsr1    = lfsr_step(lfsr_q);
    assign lfsr2    = lfsr_step(lfsr1);
    assign new_bits = (mode_in == M_QPSK) ? {lfsr_q[PN_ORDER-1], lfsr1[PN_ORDER-1]}
                                          : {1'b0, lfsr_q[PN_ORDER-1]};
    assign new_lfsr = (mode_in == M_QPSK) ? lfsr2 : lfsr1;
    assign new_d    = (mode_in == M_DPSK) ? (d_q ^ lfsr_q[PN_ORDER-1]) : d_q;

    // The boundary tick already addresses the ROM with the incoming symbol's parameters.
    assign cur_mode   = start ? mode_in  : mode_q;
    assign cur_bits   = start ? new_bits : sym_out;
    assign cur_d      = start ? new_d    : d_q;
    assign phase_base = start ? '0 : phase_q;

    always_comb begin
        offset = '0;
        case (cur_mode)
            M_PSK:  offset = cur_bits[0] ? '0 : HALF;
            M_DPSK: offset = cur_d ? HALF : '0;
            M_QPSK: begin
                case (cur_bits)
                    2'b00:   offset = '0;
                    2'b01:   offset = QTR;
                    2'b11:   offset = HALF;
                    default: offset = HALF + QTR;
                endcase
            end
            default: offset = '0;
        endcase
        step = (cur_mode == M_FSK && cur_bits[0]) ? STEP_MARK : ADDR_W'(1);
    end

    assign mute = (mode_q == M_IDLE) || (mode_q == M_ASK && !sym_out[0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            clk_DA     <= 1'b0;
            tick_dly_q <= 2'b00;
            sym_cnt_q  <= '0;
            first_q    <= 1'b0;
            phase_q    <= '0;
            rom_addr   <= '0;
            dac_data   <= MID;
            mode_q     <= M_IDLE;
            sym_out    <= 2'b00;
            lfsr_q     <= '1;
            d_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            clk_DA     <= (div_d >= DIV_HALF);
            tick_dly_q <= run_on ? {tick_dly_q[0], tick} : 2'b00;
            if (!run_on) begin
                sym_cnt_q <= '0;
                phase_q   <= '0;
                rom_addr  <= '0;
                dac_data  <= MID;
                first_q   <= (state_q == S_IDLE) && (state_d == S_RUN);
            end else begin
                if (tick) begin
                    first_q   <= 1'b0;
                    sym_cnt_q <= start ? '0 : sym_cnt_q + SYM_W'(1);
                    rom_addr  <= phase_base + offset;
                    phase_q   <= phase_base + step;
                end
                if (start) begin
                    mode_q  <= mode_in;
                    sym_out <= new_bits;
                    lfsr_q  <= new_lfsr;
                    d_q     <= new_d;
                end
                // ROM answers one clk after the address, so sample it two clks after the tick.
                if (tick_dly_q[1]) dac_data <= mute ? MID : rom_data;
            end
        end
    end
endmodule

// File: tb/tb_mdm_mod_core.sv
// tb/tb_mdm_mod_core.sv - randomized self-checking bench for mdm_mod_core
module tb_mdm_mod_core;
    localparam int DAC_W       = 8;
    localparam int ADDR_W      = 5;
    localparam int CLK_DIV     = 4;
    localparam int CYC_PER_SYM = 2;
    localparam int FSK_MULT    = 2;
    localparam int PN_ORDER    = 7;
    localparam int NPT         = 2 ** ADDR_W;
    localparam int SYM_LEN     = CYC_PER_SYM * NPT;
    localparam int MID         = 2 ** (DAC_W - 1);
    localparam int PN_LEN      = 600;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [2:0]        mode = 3'd0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DAC_W-1:0]  rom_data = '0;
    logic [DAC_W-1:0]  dac_data;
    logic              clk_DA;
    logic              blank_DA_n;
    logic              sync_DA_n;
    logic              sym_strobe;
    logic [1:0]        sym_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_strobe_cyc = 0;

    int pn [PN_LEN];
    int pn_idx;
    int dm;

    int obs_addr [SYM_LEN];
    int obs_dac  [SYM_LEN];
    int obs_sym, obs_gap, obs_clk_bad, obs_pin_bad, obs_extra;
    bit obs_to;

    mdm_mod_core #(
        .DAC_W(DAC_W), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV),
        .CYC_PER_SYM(CYC_PER_SYM), .FSK_MULT(FSK_MULT), .PN_ORDER(PN_ORDER)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .rom_addr(rom_addr), .rom_data(rom_data), .dac_data(dac_data),
        .clk_DA(clk_DA), .blank_DA_n(blank_DA_n), .sync_DA_n(sync_DA_n),
        .sym_strobe(sym_strobe), .sym_out(sym_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rom_fn(input int a);
        return (a * 37 + 11) % 256;
    endfunction

    always @(posedge clk) rom_data <= DAC_W'(rom_fn(int'(rom_addr)));

    // x^7+x^6+1 output stream, MSB-first from an all-ones seed: o[n+7] = o[n] ^ o[n+1]
    task automatic build_pn();
        for (int k = 0; k < PN_LEN; k++) pn[k] = (k < 7) ? 1 : (pn[k-7] ^ pn[k-6]);
    endtask

    task automatic model_next(input logic [2:0] m, output logic [1:0] bits, output int off,
                              output int st, output bit mute);
        int q;
        if (m == 3'd5) begin
            bits = {pn[pn_idx][0], pn[pn_idx+1][0]};
            pn_idx += 2;
        end else begin
            bits = {1'b0, pn[pn_idx][0]};
            pn_idx += 1;
        end
        if (m == 3'd4) dm = dm ^ int'(bits[0]);
        case (bits)
            2'b00:   q = 0;
            2'b01:   q = 1;
            2'b11:   q = 2;
            default: q = 3;
        endcase
        case (m)
            3'd3:    off = bits[0] ? 0 : NPT / 2;
            3'd4:    off = dm * (NPT / 2);
            3'd5:    off = q * (NPT / 4);
            default: off = 0;
        endcase
        st   = (m == 3'd2 && bits[0]) ? FSK_MULT : 1;
        mute = (m == 3'd0) || (m == 3'd1 && bits[0] == 1'b0);
    endtask

    function automatic int first_addr_bad(input int st, input int off);
        for (int i = 0; i < SYM_LEN; i++)
            if (obs_addr[i] != (i * st + off) % NPT) return i;
        return -1;
    endfunction

    function automatic int first_dac_bad(input int st, input int off, input bit mute);
        for (int i = 0; i < SYM_LEN; i++)
            if (obs_dac[i] != (mute ? MID : rom_fn((i * st + off) % NPT))) return i;
        return -1;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        mode    = 3'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        pn_idx  = 0;
        dm      = 0;
    endtask

    // Waits for sym_strobe, then records one full symbol; optionally changes mode/enable at tick act_at.
    task automatic capture(input int act_at, input logic [2:0] new_mode, input logic new_en);
        int n;
        n = 0;
        obs_to = 1'b0;
        while (sym_strobe !== 1'b1 && n < 2 * SYM_LEN * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        if (sym_strobe !== 1'b1) begin
            obs_to = 1'b1;
            return;
        end
        obs_gap = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
        obs_clk_bad = 0;
        obs_pin_bad = 0;
        obs_extra = 0;
        for (int i = 0; i < SYM_LEN; i++) begin
            for (int k = 0; k < CLK_DIV; k++) begin
                @(negedge clk);
                if (k == 0) obs_addr[i] = int'(rom_addr);
                if (k == 0 && i == 0) obs_sym = int'(sym_out);
                if (k == 2) obs_dac[i] = int'(dac_data);
                if (clk_DA !== (k >= CLK_DIV / 2)) obs_clk_bad++;
                if (blank_DA_n !== 1'b1 || sync_DA_n !== 1'b0) obs_pin_bad++;
                if (sym_strobe === 1'b1 && !(i == SYM_LEN - 1 && k == CLK_DIV - 1)) obs_extra++;
                if (k == 1 && i == act_at) begin
                    mode = new_mode;
                    enable = new_en;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 7;
        if (dac_data !== DAC_W'(MID)) begin errors++; $display("FAIL reset_dac got %0h want %0h", dac_data, MID); end
        if (rom_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
        if (clk_DA !== 1'b0) begin errors++; $display("FAIL reset_clk_DA got %b want 0", clk_DA); end
        if (blank_DA_n !== 1'b0) begin errors++; $display("FAIL reset_blank got %b want 0", blank_DA_n); end
        if (sync_DA_n !== 1'b1) begin errors++; $display("FAIL reset_sync got %b want 1", sync_DA_n); end
        if (sym_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", sym_strobe); end
        if (sym_out !== 2'b00) begin errors++; $display("FAIL reset_sym got %0d want 0", sym_out); end
    endtask

    // Shared body for single-mode runs; every comparison is made right here.
    task automatic run_mode(input string tag, input logic [2:0] m, input int nsym);
        logic [1:0] bits;
        int off, st, b;
        bit mute;
        do_reset();
        mode = m;
        enable = 1'b1;
        for (int s = 0; s < nsym; s++) begin
            capture(-1, m, 1'b1);
            checks++;
            if (obs_to) begin
                errors++;
                $display("FAIL %s_timeout sym %0d got no strobe want strobe", tag, s);
                return;
            end
            model_next(m, bits, off, st, mute);
            checks += 6;
            if (obs_sym !== int'(bits)) begin errors++; $display("FAIL %s_sym sym %0d got %0d want %0d", tag, s, obs_sym, bits); end
            b = first_addr_bad(st, off);
            if (b !== -1) begin errors++; $display("FAIL %s_addr sym %0d tick %0d got %0d want %0d", tag, s, b, obs_addr[b], (b * st + off) % NPT); end
            b = first_dac_bad(st, off, mute);
            if (b !== -1) begin errors++; $display("FAIL %s_dac sym %0d tick %0d got %0d want %0d", tag, s, b, obs_dac[b], mute ? MID : rom_fn((b * st + off) % NPT)); end
            if (obs_clk_bad !== 0) begin errors++; $display("FAIL %s_clk_DA sym %0d got %0d bad samples want 0", tag, s, obs_clk_bad); end
            if (obs_pin_bad !== 0) begin errors++; $display("FAIL %s_pins sym %0d got %0d bad samples want 0", tag, s, obs_pin_bad); end
            if (obs_extra !== 0) begin errors++; $display("FAIL %s_strobe_width sym %0d got %0d extra want 0", tag, s, obs_extra); end
            if (s > 0) begin
                checks++;
                if (obs_gap !== SYM_LEN * CLK_DIV) begin errors++; $display("FAIL %s_gap sym %0d got %0d want %0d", tag, s, obs_gap, SYM_LEN * CLK_DIV); end
            end
        end
    endtask

    task automatic test_psk();  run_mode("psk", 3'd3, 6);  endtask
    task automatic test_qpsk(); run_mode("qpsk", 3'd5, 8); endtask
    task automatic test_fsk();  run_mode("fsk", 3'd2, 10); endtask
    task automatic test_ask();  run_mode("ask", 3'd1, 12); endtask

    task automatic test_dpsk();
        int hist [130];
        int prev0, b, off, st;
        logic [1:0] bits;
        bit mute;
        do_reset();
        mode = 3'd4;
        enable = 1'b1;
        prev0 = 0;
        for (int s = 0; s < 130; s++) begin
            capture(-1, 3'd4, 1'b1);
            checks++;
            if (obs_to) begin errors++; $display("FAIL dpsk_timeout sym %0d got no strobe want strobe", s); return; end
            model_next(3'd4, bits, off, st, mute);
            hist[s] = obs_sym;
            checks += 3;
            if (obs_sym !== int'(bits)) begin errors++; $display("FAIL dpsk_sym sym %0d got %0d want %0d", s, obs_sym, bits); end
            b = first_addr_bad(st, off);
            if (b !== -1) begin errors++; $display("FAIL dpsk_addr sym %0d tick %0d got %0d want %0d", s, b, obs_addr[b], (b * st + off) % NPT); end
            if ((obs_addr[0] != prev0) !== (bits[0] == 1'b1)) begin
                errors++;
                $display("FAIL dpsk_toggle sym %0d got start %0d after %0d want toggle=%0d", s, obs_addr[0], prev0, bits[0]);
            end
            prev0 = obs_addr[0];
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hist[k + 127] !== hist[k]) begin errors++; $display("FAIL dpsk_period sym %0d got %0d want %0d", k + 127, hist[k + 127], hist[k]); end
        end
    endtask

    task automatic test_mode_change();
        logic [2:0] cur, nxt;
        logic [1:0] bits;
        int off, st, b;
        bit mute;
        do_reset();
        cur = 3'($urandom_range(1, 5));
        mode = cur;
        enable = 1'b1;
        for (int s = 0; s < 12; s++) begin
            nxt = (s == 11) ? 3'd7 : 3'($urandom_range(1, 5));
            capture($urandom_range(1, SYM_LEN - 2), nxt, 1'b1);
            checks++;
            if (obs_to) begin errors++; $display("FAIL mix_timeout sym %0d got no strobe want strobe", s); return; end
            model_next(cur, bits, off, st, mute);
            checks += 3;
            if (obs_sym !== int'(bits)) begin errors++; $display("FAIL mix_sym sym %0d mode %0d got %0d want %0d", s, cur, obs_sym, bits); end
            b = first_addr_bad(st, off);
            if (b !== -1) begin errors++; $display("FAIL mix_addr sym %0d mode %0d tick %0d got %0d want %0d", s, cur, b, obs_addr[b], (b * st + off) % NPT); end
            b = first_dac_bad(st, off, mute);
            if (b !== -1) begin errors++; $display("FAIL mix_dac sym %0d mode %0d tick %0d got %0d want %0d", s, cur, b, obs_dac[b], mute ? MID : rom_fn((b * st + off) % NPT)); end
            cur = nxt;
        end
        capture(-1, 3'd7, 1'b1);
        checks += 3;
        if (obs_to) begin errors++; $display("FAIL mode7_timeout got no strobe want strobe"); return; end
        b = first_addr_bad(1, 0);
        if (b !== -1) begin errors++; $display("FAIL mode7_addr tick %0d got %0d want %0d", b, obs_addr[b], b % NPT); end
        b = first_dac_bad(1, 0, 1'b1);
        if (b !== -1) begin errors++; $display("FAIL mode7_dac tick %0d got %0d want %0d", b, obs_dac[b], MID); end
    endtask

    task automatic test_disable();
        logic [2:0] m;
        logic [1:0] bits;
        int off, st, b, strobes;
        bit mute;
        do_reset();
        m = 3'($urandom_range(1, 5));
        mode = m;
        enable = 1'b1;
        capture(-1, m, 1'b1);
        model_next(m, bits, off, st, mute);
        capture($urandom_range(2, SYM_LEN - 2), m, 1'b0);
        checks++;
        if (obs_to) begin errors++; $display("FAIL dis_timeout got no strobe want strobe"); return; end
        model_next(m, bits, off, st, mute);
        checks += 3;
        b = first_addr_bad(st, off);
        if (b !== -1) begin errors++; $display("FAIL dis_addr tick %0d got %0d want %0d", b, obs_addr[b], (b * st + off) % NPT); end
        if (obs_pin_bad !== 0) begin errors++; $display("FAIL dis_complete got %0d blanked samples want 0", obs_pin_bad); end
        if (blank_DA_n !== 1'b1) begin errors++; $display("FAIL dis_last_tick_blank got %b want 1", blank_DA_n); end
        @(negedge clk);
        checks += 4;
        if (blank_DA_n !== 1'b0) begin errors++; $display("FAIL dis_blank got %b want 0", blank_DA_n); end
        if (sync_DA_n !== 1'b1) begin errors++; $display("FAIL dis_sync got %b want 1", sync_DA_n); end
        if (dac_data !== DAC_W'(MID)) begin errors++; $display("FAIL dis_dac got %0h want %0h", dac_data, MID); end
        if (clk_DA !== 1'b0) begin errors++; $display("FAIL dis_clk_DA got %b want 0", clk_DA); end
        strobes = 0;
        repeat (40) begin
            @(negedge clk);
            if (sym_strobe === 1'b1 || blank_DA_n !== 1'b0) strobes++;
        end
        checks++;
        if (strobes !== 0) begin errors++; $display("FAIL dis_stays_idle got %0d active samples want 0", strobes); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] bits;
        int off, st, b;
        bit mute;
        do_reset();
        mode = 3'($urandom_range(1, 5));
        enable = 1'b1;
        capture(-1, mode, 1'b1);
        repeat ($urandom_range(50, 150)) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks += 7;
        if (dac_data !== DAC_W'(MID)) begin errors++; $display("FAIL rmid_dac got %0h want %0h", dac_data, MID); end
        if (rom_addr !== '0) begin errors++; $display("FAIL rmid_addr got %0d want 0", rom_addr); end
        if (clk_DA !== 1'b0) begin errors++; $display("FAIL rmid_clk_DA got %b want 0", clk_DA); end
        if (blank_DA_n !== 1'b0) begin errors++; $display("FAIL rmid_blank got %b want 0", blank_DA_n); end
        if (sync_DA_n !== 1'b1) begin errors++; $display("FAIL rmid_sync got %b want 1", sync_DA_n); end
        if (sym_strobe !== 1'b0) begin errors++; $display("FAIL rmid_strobe got %b want 0", sym_strobe); end
        if (sym_out !== 2'b00) begin errors++; $display("FAIL rmid_sym got %0d want 0", sym_out); end
        @(negedge clk);
        reset_n = 1'b1;
        pn_idx = 0;
        dm = 0;
        mode = 3'd3;
        capture(-1, 3'd3, 1'b1);
        checks++;
        if (obs_to) begin errors++; $display("FAIL rmid_timeout got no strobe want strobe"); return; end
        model_next(3'd3, bits, off, st, mute);
        checks += 2;
        if (obs_sym !== int'(bits)) begin errors++; $display("FAIL rmid_seed_bit got %0d want %0d", obs_sym, bits); end
        b = first_addr_bad(st, off);
        if (b !== -1) begin errors++; $display("FAIL rmid_addr tick %0d got %0d want %0d", b, obs_addr[b], (b * st + off) % NPT); end
    endtask

    initial begin
        build_pn();
        test_reset();
        test_psk();
        test_qpsk();
        test_fsk();
        test_ask();
        test_dpsk();
        test_mode_change();
        test_disable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
